// File: rtl/simon_pkg.sv
// simon_pkg: shared constants, types and helper functions for the
// SIMON 128/256 iterative core.
//   WORD          - data/key word width (64)
//   ROUNDS        - number of cipher rounds (72)
//   KEYEXP_CYCLES - forward key-expansion cycles before a decrypt (68)
//   Z4            - round-constant sequence, used LSB first
//   state_t       - controller state encoding
package simon_pkg;

    localparam int WORD          = 64;
    localparam int ROUNDS        = 72;
    localparam int KEYEXP_CYCLES = 68;

    localparam logic [61:0] Z4 = 62'h3DC94C3A046D678B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [WORD-1:0] rotl(input logic [WORD-1:0] v, input int n);
        return (v << n) | (v >> (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] v, input int n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    // SIMON round function.
    function automatic logic [WORD-1:0] f(input logic [WORD-1:0] x);
        return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
    endfunction

    // z4[i mod 62] for any 7-bit index (0..127).
    function automatic logic z_bit(input logic [6:0] i);
        logic [6:0] m;
        if (i >= 7'd124) begin
            m = i - 7'd124;
        end else if (i >= 7'd62) begin
            m = i - 7'd62;
        end else begin
            m = i;
        end
        return Z4[m[5:0]];
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// simon_key_step: combinational one-step move of the 4-word key window.
//   win      in  256  window, win[63:0] = lowest-index key word
//   idx      in  7    schedule index i
//   reverse  in  1    0: k[i..i+3] -> k[i+1..i+4]
//                     1: k[i+1..i+4] -> k[i..i+3]
//   next_win out 256  moved window, same packing as win
module simon_key_step
    import simon_pkg::*;
(
    input  logic [255:0] win,
    input  logic [6:0]   idx,
    input  logic         reverse,
    output logic [255:0] next_win
);

    logic [WORD-1:0] w0_s, w1_s, w2_s, w3_s;
    logic [WORD-1:0] t_fwd_s, t_rev_s;
    logic [WORD-1:0] zc_s;

    assign w0_s = win[63:0];
    assign w1_s = win[127:64];
    assign w2_s = win[191:128];
    assign w3_s = win[255:192];

    // Round constant word: z bit in position 0, combined with the fixed 3.
    assign zc_s = {63'd0, z_bit(idx)} ^ 64'd3;

    // Mixing term; window slot holding k[i+1]/k[i+3] differs per direction.
    always_comb begin
        t_fwd_s = rotr(w3_s, 3) ^ w1_s;
        t_fwd_s = t_fwd_s ^ rotr(t_fwd_s, 1);
        t_rev_s = rotr(w2_s, 3) ^ w0_s;
        t_rev_s = t_rev_s ^ rotr(t_rev_s, 1);
    end

    // Select the forward or reverse moved window.
    always_comb begin
        next_win = win;
        if (reverse) begin
            next_win = {w2_s, w1_s, w0_s, ~(w3_s ^ t_rev_s ^ zc_s)};
        end else begin
            next_win = {~w0_s ^ t_fwd_s ^ zc_s, w3_s, w2_s, w1_s};
        end
    end

endmodule

// File: rtl/simon_128_256.sv
// simon_128_256: iterative SIMON 128/256 encrypt/decrypt core, one round
// per clock, with a sliding 4-word key window.
//   clk   in  1    rising-edge clock
//   res   in  1    synchronous active-high reset
//   start in  1    launch request (honoured in IDLE and DONE)
//   ctrl  in  1    1 = decrypt, 0 = encrypt, sampled with start
//   keys  in  256  key, keys[63:0] = k0 ... keys[255:192] = k3
//   in    in  128  input block, in[127:64] = x, in[63:0] = y
//   out   out 128  result block, zero unless done
//   done  out 1    result valid
module simon_128_256
    import simon_pkg::*;
(
    input  logic         clk,
    input  logic         res,
    input  logic         start,
    input  logic         ctrl,
    input  logic [255:0] keys,
    input  logic [127:0] in,
    output logic [127:0] out,
    output logic         done
);

    state_t          state_r;
    logic [6:0]      cnt_r;
    logic            dec_r;
    logic [WORD-1:0] x_r, y_r;
    logic [255:0]    kwin_r;

    logic [WORD-1:0] rk_s;
    logic [WORD-1:0] nx_s, ny_s;
    logic            rev_s;
    logic [6:0]      idx_s;
    logic [255:0]    kwin_next_s;

    // Decrypt walks the schedule backward, so its round key sits in the
    // top slot of the window; encrypt uses the bottom slot.
    assign rk_s = dec_r ? kwin_r[255:192] : kwin_r[63:0];

    // Next round state for the active direction.
    always_comb begin
        nx_s = x_r;
        ny_s = y_r;
        if (dec_r) begin
            nx_s = y_r;
            ny_s = x_r ^ f(y_r) ^ rk_s;
        end else begin
            nx_s = y_r ^ f(x_r) ^ rk_s;
            ny_s = x_r;
        end
    end

    // Key-step control: reverse only during decrypt rounds. Decrypt round
    // cnt uses k[71-cnt], so the step back regenerates k[67-cnt]; the last
    // few decrypt steps produce unused words.
    always_comb begin
        rev_s = 1'b0;
        idx_s = cnt_r;
        if ((state_r == ROUND) && dec_r) begin
            rev_s = 1'b1;
            idx_s = 7'd67 - cnt_r;
        end else begin
            rev_s = 1'b0;
            idx_s = cnt_r;
        end
    end

    simon_key_step u_key_step (
        .win      (kwin_r),
        .idx      (idx_s),
        .reverse  (rev_s),
        .next_win (kwin_next_s)
    );

    // Controller and datapath registers, outputs registered.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r <= IDLE;
            cnt_r   <= 7'd0;
            dec_r   <= 1'b0;
            x_r     <= 64'd0;
            y_r     <= 64'd0;
            kwin_r  <= 256'd0;
            out     <= 128'd0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        x_r     <= in[127:64];
                        y_r     <= in[63:0];
                        kwin_r  <= keys;
                        dec_r   <= ctrl;
                        cnt_r   <= 7'd0;
                        out     <= 128'd0;
                        done    <= 1'b0;
                        state_r <= ctrl ? KEYEXP : ROUND;
                    end
                end
                KEYEXP: begin
                    kwin_r <= kwin_next_s;
                    if (cnt_r == 7'(KEYEXP_CYCLES - 1)) begin
                        cnt_r   <= 7'd0;
                        state_r <= ROUND;
                    end else begin
                        cnt_r <= cnt_r + 7'd1;
                    end
                end
                ROUND: begin
                    x_r    <= nx_s;
                    y_r    <= ny_s;
                    kwin_r <= kwin_next_s;
                    if (cnt_r == 7'(ROUNDS - 1)) begin
                        cnt_r   <= 7'd0;
                        out     <= {nx_s, ny_s};
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 7'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_128_256.sv
// tb_simon_128_256: randomized scoreboard bench for simon_128_256 with a
// behavioural SIMON 128/256 model (full key schedule array + round loop).
module tb_simon_128_256;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         start = 1'b0;
    logic         ctrl = 1'b0;
    logic [255:0] keys = 256'd0;
    logic [127:0] in = 128'd0;
    logic [127:0] out;
    logic         done;

    simon_128_256 dut (
        .clk   (clk),
        .res   (res),
        .start (start),
        .ctrl  (ctrl),
        .keys  (keys),
        .in    (in),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] val;
        int           start_cyc;
        int           lat;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;
    logic done_prev = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_rotl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] m_rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [127:0] model(input logic [255:0] key,
                                           input logic [127:0] blk,
                                           input logic dec);
        logic [63:0] k [72];
        logic [61:0] z;
        logic [63:0] t, x, y, tmp, fx;
        z = 62'h3DC94C3A046D678B;
        for (int i = 0; i < 4; i++) k[i] = key[64*i +: 64];
        for (int i = 0; i < 68; i++) begin
            t = m_rotr(k[i+3], 3) ^ k[i+1];
            t = t ^ m_rotr(t, 1);
            k[i+4] = ~k[i] ^ t ^ {63'd0, z[i % 62]} ^ 64'd3;
        end
        x = blk[127:64];
        y = blk[63:0];
        if (!dec) begin
            for (int i = 0; i < 72; i++) begin
                fx  = (m_rotl(x, 1) & m_rotl(x, 8)) ^ m_rotl(x, 2);
                tmp = x;
                x   = y ^ fx ^ k[i];
                y   = tmp;
            end
        end else begin
            for (int i = 71; i >= 0; i--) begin
                fx  = (m_rotl(y, 1) & m_rotl(y, 8)) ^ m_rotl(y, 2);
                tmp = y;
                y   = x ^ fx ^ k[i];
                x   = tmp;
            end
        end
        return {x, y};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done && !done_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: out=%h with no pending operation", out);
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e.val) begin
                        fails++;
                        $display("FAIL %s_out: got %h expected %h", e.name, out, e.val);
                    end
                    checks++;
                    if (cyc - e.start_cyc != e.lat) begin
                        fails++;
                        $display("FAIL %s_latency: got %0d expected %0d", e.name, cyc - e.start_cyc, e.lat);
                    end
                end
            end
            if (!done) begin
                checks++;
                if (out !== 128'd0) begin
                    fails++;
                    $display("FAIL out_zero_when_idle: got %h expected 0", out);
                end
            end
        end
        done_prev = done;
    end

    // ---------------- driver helpers ----------------
    // Call right after a negedge; returns #1 after the sampling edge.
    task automatic launch(input logic [255:0] k, input logic [127:0] b, input logic d,
                          input logic [127:0] expv, input string nm);
        exp_t e;
        keys  = k;
        in    = b;
        ctrl  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.val = expv;
        e.start_cyc = cyc;
        e.lat = d ? 140 : 72;
        e.name = nm;
        exp_q.push_back(e);
        keys = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in   = {$urandom, $urandom, $urandom, $urandom};
        ctrl = $urandom_range(0, 1);
    endtask

    // Returns at the negedge where done is first seen high.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: done=%b expected 1 within 200 cycles", nm, done);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        checks++;
        if (out !== 128'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out=%h done=%b expected 0/0", out, done);
        end
    endtask

    // ---------------- stimulus ----------------
    localparam logic [255:0] STD_KEY = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] STD_PT  = 128'h74206e69206d6f6f6d69732061207369;
    localparam logic [127:0] STD_CT  = 128'h8d2b5579afc8a3a03bf72a87efe7b868;
    localparam logic [127:0] ZK_IN1  = 128'h4617626D9D4BBD60A1FE607B736A0C0C;

    initial begin
        logic [255:0] rk;
        logic [127:0] rb, cap;
        logic         rd;
        int           n;

        pulse_reset();
        mon_en = 1'b1;

        // Standard vectors, constant expectations.
        @(negedge clk);
        launch(STD_KEY, STD_PT, 1'b0, STD_CT, "std_enc");
        wait_done("std_enc");
        @(negedge clk);
        launch(STD_KEY, STD_CT, 1'b1, STD_PT, "std_dec");
        wait_done("std_dec");

        // Zero key: decrypt, reset, encrypt, reset, encrypt the decrypt result.
        pulse_reset();
        @(negedge clk);
        launch(256'd0, ZK_IN1, 1'b1, model(256'd0, ZK_IN1, 1'b1), "zk_dec");
        wait_done("zk_dec");
        cap = out;
        pulse_reset();
        @(negedge clk);
        launch(256'd0, STD_PT, 1'b0, model(256'd0, STD_PT, 1'b0), "zk_enc");
        wait_done("zk_enc");
        pulse_reset();
        @(negedge clk);
        launch(256'd0, cap, 1'b0, ZK_IN1, "zk_inverse");
        wait_done("zk_inverse");

        // Reset mid-operation, then a fresh operation at full latency.
        @(negedge clk);
        launch(STD_KEY, STD_PT, 1'b0, STD_CT, "abandoned");
        repeat (30) @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if (out !== 128'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset: out=%h done=%b expected 0/0", out, done);
        end
        @(negedge clk);
        launch(STD_KEY, STD_CT, 1'b1, STD_PT, "after_reset");
        wait_done("after_reset");

        // Start pulses while busy are ignored.
        for (int j = 0; j < 2; j++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rd = j[0];
            @(negedge clk);
            launch(rk, rb, rd, model(rk, rb, rd), "busy_start");
            repeat (20 + 50 * j) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done("busy_start");
        end

        // Back-to-back random operations launched from DONE.
        for (int j = 0; j < 6; j++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            launch(rk, rb, rd, model(rk, rb, rd), "b2b_rand");
            checks++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL b2b_done_drop: done=%b expected 0", done);
            end
            wait_done("b2b_rand");
        end

        // Drain the scoreboard.
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d pending results expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/simon_128_256.md
Name: simon_128_256

Overview:
- Iterative SIMON 128/256 block cipher core: 64-bit words, 4 key words, 72 rounds, one round per clock.
- Encrypts or decrypts one 128-bit block under a 256-bit key per start pulse; done flags a valid result.
- Sits as a standalone crypto datapath behind a simple start/done handshake.

Parameters:
- None. Word width 64, rounds 72 and key words 4 are fixed constants.

Ports:
- clk  in  1  Rising-edge clock.
- res  in  1  Reset; one clock, synchronous, active-high.
- start  in  1  Launch request; sampled on a clk edge.
- ctrl  in  1  1 = decrypt, 0 = encrypt; sampled with start.
- keys  in  256  Key. keys[63:0] = k0, keys[127:64] = k1, keys[191:128] = k2, keys[255:192] = k3.
- in  in  128  Input block. in[127:64] = x, in[63:0] = y.
- out  out  128  Result block, same x/y packing as in. Valid while done = 1.
- done  out  1  High when out holds the finished result.

Behaviour:
- Reset (res = 1 at an edge): state IDLE, out = 0, done = 0, all internal registers cleared. Reset has priority over everything, including an operation in progress, which is abandoned with no output.
- f(x) = (rotl(x,1) & rotl(x,8)) ^ rotl(x,2).
- Encrypt round i: (x,y) <= (y ^ f(x) ^ k_i, x), for i = 0..71.
- Decrypt round: (x,y) <= (y, x ^ f(y) ^ k_i), for i = 71 down to 0.
- Key schedule, forward:
  - t = rotr(k[i+3],3) ^ k[i+1]
  - t = t ^ rotr(t,1)
  - k[i+4] = ~k[i] ^ t ^ z4[i mod 62] ^ 64'd3
- z4 = 62'h3DC94C3A046D678B, indexed LSB-first (bit 0 used at i = 0).
- Key schedule, reverse: k[i] = ~(k[i+4] ^ t ^ z4[i mod 62] ^ 3), with t computed as above from k[i+1] and k[i+3].
- Key storage: 4-word sliding window only. No 72-entry round-key RAM.
- States:
  - IDLE: on start, latch in, keys and ctrl, and clear done. Go to ROUND if ctrl = 0, KEYEXP if ctrl = 1.
  - KEYEXP (decrypt only): 68 cycles of forward key expansion, leaving window = k68..k71. Then ROUND.
  - ROUND: 72 cycles, one round per cycle. Encrypt steps the key window forward; decrypt steps it backward.
  - DONE: out = final (x,y), done = 1, both held.
- Latency, counted in edges after the start-sampling edge:
  - Encrypt: done and out valid at edge 72.
  - Decrypt: done and out valid at edge 140.
- start while busy (KEYEXP/ROUND) is ignored.
- start in DONE launches a new operation and drops done on that same edge.
- start and res together: res wins.
- Inputs may change freely after the sampling edge.
- out = 0 while not done.
- Round counter: 7 bits. Must terminate exactly at 72 (no wrap); KEYEXP counts 68.

Decomposition:
- Package simon_pkg holds:
  - WORD = 64, ROUNDS = 72, KEYEXP_CYCLES = 68
  - Z4 constant
  - function f
  - state enum {IDLE, KEYEXP, ROUND, DONE}
- Sub-module simon_key_step: combinational forward/reverse key step. Inputs are a 4-word window, round index and direction; output is the next window.

Test Plan:
- Encrypt standard vector: keys = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100, in = 128'h74206e69206d6f6f6d69732061207369, ctrl = 0 -> out = 128'h8d2b5579afc8a3a03bf72a87efe7b868, done high at edge 72.
- Decrypt same vector: in = 128'h8d2b5579afc8a3a03bf72a87efe7b868, ctrl = 1 -> out = 128'h74206e69206d6f6f6d69732061207369, done at edge 140.
- Zero key, two runs separated by res pulses:
  - decrypt in = 128'h4617626D9D4BBD60A1FE607B736A0C0C;
  - encrypt in = 128'h74206E69206D6F6F6D69732061207369;
  - the two outputs must be mutual inverses, each checked against a software model.
- Reset mid-operation: assert res at round 30 -> out = 0, done = 0. A new start then produces the correct result at full latency.
- start pulsed during ROUND -> ignored; result and latency unchanged.
- Back-to-back operation: start in DONE -> done low next edge, new result after full latency, no reset needed.
